// File: rtl/pwm_bank_pkg.sv
// Shared constants and helpers for the PWM bank register map.
package pwm_bank_pkg;

    // Register offsets above the per-channel threshold block (base = NUM_PWM)
    localparam int ADDR_OFS_PERIOD = 0;
    localparam int ADDR_OFS_CTRL   = 1;
    localparam int ADDR_OFS_POL    = 2;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_FORCE_BIT = 1;

    typedef enum logic [2:0] {
        WR_NONE,
        WR_THRES,
        WR_PERIOD,
        WR_CTRL,
        WR_POL
    } wr_kind_e;

    function automatic int roundup8(input int x);
        return ((x + 7) / 8) * 8;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active threshold pair and the registered compare.
module pwm_channel #(
    parameter int PWM_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [PWM_WIDTH-1:0] wr_data,
    input  logic                 commit,
    input  logic                 enable,
    input  logic [PWM_WIDTH-1:0] counter,
    input  logic                 polarity,
    output logic                 pwm_out,
    output logic                 pending
);

    logic [PWM_WIDTH-1:0] shadow_thres;
    logic [PWM_WIDTH-1:0] active_thres;

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_thres <= '0;
            active_thres <= '0;
            pwm_out      <= 1'b0;
        end else begin
            if (wr_en)
                shadow_thres <= wr_data;
            // A write landing on the commit edge goes straight through to active.
            if (commit)
                active_thres <= wr_en ? wr_data : shadow_thres;
            pwm_out <= (enable && (counter < active_thres)) ^ polarity;
        end
    end

    assign pending = (shadow_thres != active_thres);

endmodule

// File: rtl/pwm_bank.sv
// Bank of NUM_PWM shadowed PWM channels sharing one period counter.
// Optional feature: define PWM_BANK_POLARITY_EN for a per-channel output polarity register.
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int PWM_WIDTH  = 16,
    parameter int NUM_PWM    = 12,
    parameter int ADDR_WIDTH = $clog2(NUM_PWM + 3)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [PWM_WIDTH-1:0]  wr_data,
    output logic [NUM_PWM-1:0]    pwm_out,
    output logic                  wrap,
    output logic                  update_pending
);

    wr_kind_e             wr_kind;
    logic [PWM_WIDTH-1:0] counter;
    logic [PWM_WIDTH-1:0] shadow_period;
    logic [PWM_WIDTH-1:0] active_period;
    logic                 enable;
    logic                 at_wrap;
    logic                 force_commit;
    logic                 commit;
    logic [NUM_PWM-1:0]   chan_pending;
    logic [NUM_PWM-1:0]   polarity;

    always_comb begin
        wr_kind = WR_NONE;
        if (wr_valid) begin
            if (int'(wr_addr) < NUM_PWM)
                wr_kind = WR_THRES;
            else if (int'(wr_addr) == NUM_PWM + ADDR_OFS_PERIOD)
                wr_kind = WR_PERIOD;
            else if (int'(wr_addr) == NUM_PWM + ADDR_OFS_CTRL)
                wr_kind = WR_CTRL;
`ifdef PWM_BANK_POLARITY_EN
            else if (int'(wr_addr) == NUM_PWM + ADDR_OFS_POL)
                wr_kind = WR_POL;
`endif
        end
    end

    assign at_wrap      = enable && (counter == active_period);
    assign force_commit = (wr_kind == WR_CTRL) && wr_data[CTRL_FORCE_BIT];
    assign commit       = at_wrap || force_commit;

    always_ff @(posedge clk) begin
        if (reset) begin
            counter       <= '0;
            shadow_period <= '1;
            active_period <= '1;
            enable        <= 1'b0;
            wrap          <= 1'b0;
        end else begin
            wrap <= at_wrap;
            if (wr_kind == WR_PERIOD)
                shadow_period <= wr_data;
            if (commit)
                active_period <= (wr_kind == WR_PERIOD) ? wr_data : shadow_period;
            if (wr_kind == WR_CTRL)
                enable <= wr_data[CTRL_EN_BIT];
            if (force_commit || !enable || at_wrap)
                counter <= '0;
            else
                counter <= counter + PWM_WIDTH'(1);
        end
    end

`ifdef PWM_BANK_POLARITY_EN
    // Polarity is not shadowed: it takes effect on the next output register update.
    always_ff @(posedge clk) begin
        if (reset)
            polarity <= '0;
        else if (wr_kind == WR_POL)
            polarity <= NUM_PWM'(wr_data);
    end
`else
    assign polarity = '0;
`endif

    for (genvar i = 0; i < NUM_PWM; i++) begin : g_chan
        pwm_channel #(
            .PWM_WIDTH(PWM_WIDTH)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .wr_en    ((wr_kind == WR_THRES) && (wr_addr == ADDR_WIDTH'(i))),
            .wr_data  (wr_data),
            .commit   (commit),
            .enable   (enable),
            .counter  (counter),
            .polarity (polarity[i]),
            .pwm_out  (pwm_out[i]),
            .pending  (chan_pending[i])
        );
    end

    assign update_pending = (|chan_pending) || (shadow_period != active_period);

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 SHALL have parameter PWM_WIDTH, default 16, meaning counter, period and threshold width in bits (range 2..32).
REQ-002 SHALL have parameter NUM_PWM, default 12, meaning channel count (range 1..64).
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(NUM_PWM+3), meaning register address width.
REQ-004 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port wr_valid  input  1  one-cycle write strobe (the SPI deserialiser's data_ready).
REQ-007 SHALL have port wr_addr  input  ADDR_WIDTH  register address.
REQ-008 SHALL have port wr_data  input  PWM_WIDTH  write data.
REQ-009 SHALL have port pwm_out  output  NUM_PWM  registered PWM outputs.
REQ-010 SHALL have port wrap  output  1  one-cycle pulse, registered, asserted the cycle after a period wrap.
REQ-011 SHALL have port update_pending  output  1  high while any shadow register differs from its committed copy.

Function
REQ-012 Address map SHALL be: 0..NUM_PWM-1 channel threshold shadow; NUM_PWM period shadow; NUM_PWM+1 control (bit0 global enable, bit1 force-commit, self-clearing); NUM_PWM+2 polarity (see Configuration); other addresses ignored.
REQ-013 Writes SHALL land in shadow registers one cycle after wr_valid; wr_valid is accepted every cycle, with no back-pressure.
REQ-014 Counter SHALL count 0..active_period and wrap to 0; wrap is defined as counter==active_period with enable=1.
REQ-015 On wrap, all shadow thresholds and the shadow period SHALL copy to active atomically in the same edge.
REQ-016 A write coinciding with the wrap cycle SHALL be included in that commit (write-through to active).
REQ-017 A force-commit write SHALL copy all shadows to active at the next edge and reset the counter to 0.
REQ-018 pwm_out[i] SHALL be registered as enable && (counter < active_thres[i]), giving one-cycle latency from counter.
REQ-019 Boundaries: threshold 0 gives a constant-low output; threshold greater than active_period gives a constant-high output; active_period 0 means the counter stays at 0, wrap fires every cycle, and the output is high iff threshold is nonzero.
REQ-020 With enable=0 the counter SHALL hold at 0, no wrap occurs, no commit occurs, and pwm_out SHALL be 0.
REQ-021 The enable 0->1 transition SHALL start counting from 0, with the first period using the active values.

Reset
REQ-022 Reset SHALL force: counter 0; all shadow and active thresholds 0; shadow and active period all-ones; enable 0; pwm_out 0; wrap 0; update_pending 0.
REQ-023 Reset asserted mid-period SHALL discard pending shadow writes, and a write on the reset cycle SHALL be ignored.

Configuration
REQ-024 Macro PWM_BANK_POLARITY_EN SHALL, when defined, add a NUM_PWM-bit polarity register at NUM_PWM+2 (reset 0, applied immediately, not shadowed), XORed into pwm_out, so that disabled outputs idle at the polarity level.
REQ-025 Without PWM_BANK_POLARITY_EN, address NUM_PWM+2 SHALL be ignored and outputs SHALL be non-inverted.

Structure
REQ-026 Package pwm_bank_pkg SHALL hold the address-offset constants, control bit indices, and the roundup8 helper function.
REQ-027 Per-channel shadow/active/compare logic SHALL be the sub-module pwm_channel, instantiated NUM_PWM times by a generate loop.

Verification
REQ-028 Reset, enable=1, ch0 thres=4, period=9 via force-commit -> pwm_out[0] high 4 of every 10 cycles, wrap pulse every 10 cycles.
REQ-029 Mid-period write ch0 thres=7 -> duty stays 4/10 until wrap, becomes 7/10 in the next period, update_pending high from write until commit.
REQ-030 Write of thres=2 on the exact wrap cycle -> the next period already shows 2/10.
REQ-031 thres=0 and thres=0xFFFF with period=9 -> constant low and constant high; period=0 with thres=1 -> constant high, wrap every cycle.
REQ-032 Reset asserted at counter=5 with a pending shadow write -> all outputs 0 next cycle, committed period 0xFFFF, and the pending value is lost.
REQ-033 With PWM_BANK_POLARITY_EN, polarity=0x001 and enable=0 -> pwm_out[0]=1, others 0; enable with thres=4, period=9 -> ch0 low 4 of every 10 cycles.
